run_controller: RTL and testbench
=================================

// Module: run_controller
// PURPOSE
//  Sequences the CPU clock-enable (o_halt) from front-panel controls: free run, single cycle step,
//  single instruction step and hardware breakpoints. Debounces the step button, synchronises the
//  panel switches and runs a Moore FSM whose state drives o_halt to the datapath clock enable.
//  Sits between the panel inputs and the CPU core; the core supplies instruction-finished and
//  breakpoint-hit strobes.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  cycles the synchronised step button must be stable before accepted
//  MAX_INSTR_CYCLES 64     watchdog: max enabled cycles in one instruction step before forced halt
//  CNT_W            16     width of o_instrCount
// PORTS
//  i_clk                 in   1     system clock, all logic rising-edge
//  i_resetn              in   1     asynchronous active-low reset
//  i_btnStep             in   1     step button, 1 = pressed, raw/bouncy
//  i_swInstrNCycle       in   1     1 = step by instruction, 0 = step by cycle
//  i_swStepNRun          in   1     1 = step mode, 0 = run mode
//  i_swEnableBreakpoint  in   1     1 = breakpoints honoured
//  i_breakpointHitN      in   1     active-low, core PC matches breakpoint this cycle
//  i_ctrlInstrFinishedN  in   1     active-low, last cycle of current instruction
//  o_halt                out  1     1 = core clock enable off
//  o_breakpointEnableN   out  1     ~synchronised i_swEnableBreakpoint
//  o_state               out  3     FSM state encoding (debug LEDs)
//  o_stepTimeout         out  1     sticky: instruction step hit watchdog
//  o_instrCount          out  CNT_W instructions completed while o_halt=0, wraps
// BEHAVIOUR
//  Reset (async, i_resetn=0): state=HALT, o_halt=1, o_breakpointEnableN=1, o_stepTimeout=0,
//   o_instrCount=0, sync/debounce regs cleared (button = released).
//  Inputs: all four panel inputs pass a 2-FF synchroniser (2 cycle latency). Button then needs
//   DEBOUNCE_CYCLES consecutive equal samples to change debounced level; rising edge of
//   debounced level = 1-cycle stepPulse. Held button gives exactly one pulse.
//  o_halt is a pure decode of the state register (no input-to-output comb path).
//  States (o_state): HALT=0, RUN=1, STEP_CYC=2, STEP_INSTR=3, BP_HIT=4, DRAIN=5.
//   HALT  o_halt=1. stepN_run=0 -> RUN. stepPulse & step mode -> STEP_INSTR if instrNCycle
//         else STEP_CYC.
//   RUN   o_halt=0. bp enabled & hitN=0 & !bpMask -> BP_HIT (hit wins over switch change).
//         stepN_run=1 -> DRAIN if instrNCycle else HALT. Step pulses ignored.
//   STEP_CYC  o_halt=0 for exactly one cycle, then HALT unconditionally.
//   STEP_INSTR o_halt=0 until cycle with finishedN=0 (inclusive), then HALT. Breakpoints ignored.
//         Watchdog counts enabled cycles; at MAX_INSTR_CYCLES -> HALT, o_stepTimeout=1.
//   DRAIN o_halt=0 until finishedN=0 (inclusive) -> HALT; same watchdog as STEP_INSTR.
//   BP_HIT o_halt=1. stepPulse: step mode -> STEP_INSTR/STEP_CYC per instrNCycle;
//         run mode -> RUN with bpMask set. Disabling breakpoint in run mode -> RUN, bpMask set.
//  bpMask: set on leaving BP_HIT, cleared on first finishedN=0 with o_halt=0 (prevents re-trigger
//   on the same PC). Cleared by reset.
//  o_stepTimeout clears on next accepted stepPulse or reset.
//  o_instrCount increments on each cycle with o_halt=0 and finishedN=0; wraps 2^CNT_W-1 -> 0.
//  Step pulse in same cycle as run/step switch change: FSM uses synchronised switch values of that
//   cycle; STEP_CYC/STEP_INSTR complete even if switches change mid-step.
// TESTING
//  1 Reset low mid-RUN -> o_halt=1 same cycle, o_state=0, o_instrCount=0 after release.
//  2 Step mode, cycle, bouncy press (10 toggles <DEBOUNCE_CYCLES, then stable) -> exactly one
//    1-cycle o_halt=0 window, o_state 0->2->0.
//  3 Step mode, instr, finishedN low on 4th enabled cycle -> o_halt=0 for 4 cycles, count +1.
//  4 Run, bp enabled, hitN=0 -> o_halt=1 next cycle, state=4; run-mode press -> RUN, no re-hit
//    on same PC until an instruction finishes.
//  5 Instr step, finishedN never low, MAX_INSTR_CYCLES=8 -> halt after 8 cycles, o_stepTimeout=1.
//  6 o_instrCount at 16'hFFFF plus one finish -> 16'h0000.

Source files
------------

// File: rtl/run_controller.sv
// Purpose: sequences the CPU clock enable (o_halt) from panel run/step/breakpoint controls.
// Latency: panel inputs take 2 cycles to synchronise; the step button also waits DEBOUNCE_CYCLES.
// Backpressure: none; o_halt is a pure state decode and is the only throttle on the core.
module run_controller #(
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter int MAX_INSTR_CYCLES = 64,
  parameter int CNT_W            = 16
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_btnStep,
  input  logic             i_swInstrNCycle,
  input  logic             i_swStepNRun,
  input  logic             i_swEnableBreakpoint,
  input  logic             i_breakpointHitN,
  input  logic             i_ctrlInstrFinishedN,
  output logic             o_halt,
  output logic             o_breakpointEnableN,
  output logic [2:0]       o_state,
  output logic             o_stepTimeout,
  output logic [CNT_W-1:0] o_instrCount
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WD_W = $clog2(MAX_INSTR_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_HALT       = 3'd0,
    ST_RUN        = 3'd1,
    ST_STEP_CYC   = 3'd2,
    ST_STEP_INSTR = 3'd3,
    ST_BP_HIT     = 3'd4,
    ST_DRAIN      = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  // Two-stage synchronisers; bit 1 is the usable, metastability-filtered value.
  logic [1:0] btn_sync;
  logic [1:0] instr_sync;
  logic [1:0] step_sync;
  logic [1:0] bp_sync;

  logic btn_s;
  logic instr_mode;
  logic step_mode;
  logic bp_en;

  // Debounce state
  logic [DB_W-1:0] db_cnt;
  logic            btn_level;
  logic            btn_level_q;
  logic            step_pulse;

  // Core strobes, converted to active-high for readability
  logic bp_hit;
  logic instr_fin;

  // FSM side outputs
  logic            step_accept;
  logic            wd_fire;
  logic [WD_W-1:0] wd_cnt;
  logic            bp_mask;

  assign btn_s      = btn_sync[1];
  assign instr_mode = instr_sync[1];
  assign step_mode  = step_sync[1];
  assign bp_en      = bp_sync[1];

  assign bp_hit    = ~i_breakpointHitN;
  assign instr_fin = ~i_ctrlInstrFinishedN;

  // Synchronise the four panel inputs into the core clock domain.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      btn_sync   <= 2'b00;
      instr_sync <= 2'b00;
      step_sync  <= 2'b00;
      bp_sync    <= 2'b00;
    end else begin
      btn_sync   <= {btn_sync[0],   i_btnStep};
      instr_sync <= {instr_sync[0], i_swInstrNCycle};
      step_sync  <= {step_sync[0],  i_swStepNRun};
      bp_sync    <= {bp_sync[0],    i_swEnableBreakpoint};
    end
  end

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      db_cnt      <= '0;
      btn_level   <= 1'b0;
      btn_level_q <= 1'b0;
    end else begin
      btn_level_q <= btn_level;
      if (btn_s == btn_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_level <= btn_s;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // A held button yields a single pulse on the rising edge of the debounced level.
  assign step_pulse = btn_level & ~btn_level_q;

  // State register.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state <= ST_HALT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; also flags accepted step pulses and watchdog expiry.
  always_comb begin
    state_nxt   = state;
    step_accept = 1'b0;
    wd_fire     = 1'b0;
    case (state)
      ST_HALT: begin
        if (!step_mode) begin
          state_nxt = ST_RUN;
        end else if (step_pulse) begin
          step_accept = 1'b1;
          state_nxt   = instr_mode ? ST_STEP_INSTR : ST_STEP_CYC;
        end
      end
      ST_RUN: begin
        // A breakpoint hit takes priority over a simultaneous switch change.
        if (bp_en && bp_hit && !bp_mask) begin
          state_nxt = ST_BP_HIT;
        end else if (step_mode) begin
          // In instruction mode let the current instruction finish before halting.
          state_nxt = instr_mode ? ST_DRAIN : ST_HALT;
        end
      end
      ST_STEP_CYC: begin
        state_nxt = ST_HALT;
      end
      ST_STEP_INSTR, ST_DRAIN: begin
        if (instr_fin) begin
          state_nxt = ST_HALT;
        end else if (wd_cnt == WD_W'(MAX_INSTR_CYCLES - 1)) begin
          // Instruction never signalled completion; give up and halt.
          state_nxt = ST_HALT;
          wd_fire   = 1'b1;
        end
      end
      ST_BP_HIT: begin
        if (step_pulse) begin
          step_accept = 1'b1;
          if (step_mode) begin
            state_nxt = instr_mode ? ST_STEP_INSTR : ST_STEP_CYC;
          end else begin
            state_nxt = ST_RUN;
          end
        end else if (!step_mode && !bp_en) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_HALT;
      end
    endcase
  end

  // Watchdog counts enabled cycles spent inside one instruction step or drain.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      wd_cnt <= '0;
    end else if ((state == ST_STEP_INSTR || state == ST_DRAIN) && (state_nxt == state)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  // The breakpoint mask stops an immediate re-hit on the same PC after resuming.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      bp_mask <= 1'b0;
    end else if (state == ST_BP_HIT && state_nxt != ST_BP_HIT) begin
      bp_mask <= 1'b1;
    end else if (!o_halt && instr_fin) begin
      bp_mask <= 1'b0;
    end
  end

  // Sticky timeout flag, cleared when the operator takes the next step.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_stepTimeout <= 1'b0;
    end else if (wd_fire) begin
      o_stepTimeout <= 1'b1;
    end else if (step_accept) begin
      o_stepTimeout <= 1'b0;
    end
  end

  // Count instructions that retire while the core is enabled; wraps naturally.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_instrCount <= '0;
    end else if (!o_halt && instr_fin) begin
      o_instrCount <= o_instrCount + CNT_W'(1);
    end
  end

  assign o_halt              = (state == ST_HALT) || (state == ST_BP_HIT);
  assign o_state             = state;
  assign o_breakpointEnableN = ~bp_en;

endmodule

// File: tb/tb_run_controller.sv
module tb_run_controller;

  localparam int DEB  = 8;
  localparam int MAXI = 8;
  localparam int CW   = 16;

  logic          clk;
  logic          resetn;
  logic          btn;
  logic          sw_instr;
  logic          sw_step;
  logic          sw_bp;
  logic          hit_n;
  logic          fin_n;
  logic          halt;
  logic          bp_en_n;
  logic [2:0]    state;
  logic          timeout;
  logic [CW-1:0] icount;

  run_controller #(
    .DEBOUNCE_CYCLES (DEB),
    .MAX_INSTR_CYCLES(MAXI),
    .CNT_W           (CW)
  ) dut (
    .i_clk               (clk),
    .i_resetn            (resetn),
    .i_btnStep           (btn),
    .i_swInstrNCycle     (sw_instr),
    .i_swStepNRun        (sw_step),
    .i_swEnableBreakpoint(sw_bp),
    .i_breakpointHitN    (hit_n),
    .i_ctrlInstrFinishedN(fin_n),
    .o_halt              (halt),
    .o_breakpointEnableN (bp_en_n),
    .o_state             (state),
    .o_stepTimeout       (timeout),
    .o_instrCount        (icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int model_cnt   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] win_q[$];
  int          run_len = 0;

  // Record the length of every contiguous window with the core enabled.
  always @(negedge clk) begin
    if (halt === 1'b0) begin
      run_len++;
    end else begin
      if (run_len != 0) win_q.push_back(32'(run_len));
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic check_windows(input string tag, input int exp_n, input int exp_len);
    logic [31:0] first_len;
    expect_val(32'(exp_n));
    check({tag, "_count"}, 32'(win_q.size()));
    first_len = (win_q.size() > 0) ? win_q[0] : 32'd0;
    expect_val(32'(exp_len));
    check({tag, "_len"}, first_len);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1);
  end

  initial begin
    int n;
    resetn   = 1'b0;
    btn      = 1'b0;
    sw_instr = 1'b0;
    sw_step  = 1'b1;
    sw_bp    = 1'b0;
    hit_n    = 1'b1;
    fin_n    = 1'b1;

    // Reset state
    repeat (3) tick();
    expect_val(32'd1); check("rst_halt", 32'(halt));
    expect_val(32'd0); check("rst_state", 32'(state));
    expect_val(32'd1); check("rst_bp_en_n", 32'(bp_en_n));
    expect_val(32'd0); check("rst_timeout", 32'(timeout));
    expect_val(32'd0); check("rst_count", 32'(icount));
    resetn = 1'b1;
    repeat (6) tick();

    // Run mode, retire three instructions, then reset mid-run
    sw_step = 1'b0;
    repeat (4) tick();
    expect_val(32'd1); check("run_state", 32'(state));
    expect_val(32'd0); check("run_halt", 32'(halt));
    fin_n = 1'b0;
    repeat (3) tick();
    fin_n = 1'b1;
    expect_val(32'd3); check("run_count", 32'(icount));
    resetn = 1'b0;
    #1;
    expect_val(32'd1); check("mid_rst_halt", 32'(halt));
    expect_val(32'd0); check("mid_rst_state", 32'(state));
    sw_step = 1'b1;
    repeat (2) tick();
    resetn = 1'b1;
    expect_val(32'd0); check("post_rst_count", 32'(icount));
    model_cnt = 0;
    repeat (6) tick();
    win_q.delete();

    // Cycle step with a bouncy press: exactly one single-cycle enable window
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      repeat (2) tick();
    end
    btn = 1'b1;
    n = 0;
    while (state == 3'd0 && n < 40) begin
      tick();
      n++;
    end
    expect_val(32'd2); check("cyc_state_step", 32'(state));
    tick();
    expect_val(32'd0); check("cyc_state_back", 32'(state));
    repeat (20) tick();
    btn = 1'b0;
    repeat (20) tick();
    check_windows("cyc_win", 1, 1);

    // Instruction step finishing on the 4th enabled cycle
    sw_instr = 1'b1;
    repeat (3) tick();
    win_q.delete();
    btn = 1'b1;
    n = 0;
    while (halt == 1'b1 && n < 40) begin
      tick();
      n++;
    end
    repeat (3) tick();
    fin_n = 1'b0;
    model_cnt++;
    tick();
    fin_n = 1'b1;
    repeat (10) tick();
    btn = 1'b0;
    repeat (20) tick();
    expect_val(32'd0); check("instr_state", 32'(state));
    check_windows("instr_win", 1, 4);
    expect_val(32'(model_cnt)); check("instr_count", 32'(icount));
    expect_val(32'd0); check("instr_timeout", 32'(timeout));

    // Instruction step that never finishes: watchdog halts after MAXI cycles
    win_q.delete();
    btn = 1'b1;
    repeat (30) tick();
    btn = 1'b0;
    repeat (20) tick();
    check_windows("wd_win", 1, MAXI);
    expect_val(32'd1); check("wd_timeout", 32'(timeout));
    expect_val(32'd0); check("wd_state", 32'(state));
    expect_val(32'(model_cnt)); check("wd_count", 32'(icount));

    // Next accepted step clears the sticky timeout
    sw_instr = 1'b0;
    repeat (3) tick();
    win_q.delete();
    btn = 1'b1;
    repeat (30) tick();
    btn = 1'b0;
    repeat (20) tick();
    expect_val(32'd0); check("wd_clear_timeout", 32'(timeout));
    check_windows("wd_clear_win", 1, 1);

    // Breakpoint in run mode, resume with a press, masked until an instruction retires
    sw_bp = 1'b1;
    repeat (3) tick();
    expect_val(32'd0); check("bp_en_n", 32'(bp_en_n));
    sw_step = 1'b0;
    repeat (4) tick();
    expect_val(32'd1); check("bp_run_state", 32'(state));
    hit_n = 1'b0;
    tick();
    expect_val(32'd4); check("bp_hit_state", 32'(state));
    expect_val(32'd1); check("bp_hit_halt", 32'(halt));
    btn = 1'b1;
    n = 0;
    while (state == 3'd4 && n < 40) begin
      tick();
      n++;
    end
    expect_val(32'd1); check("bp_resume_state", 32'(state));
    btn = 1'b0;
    repeat (12) tick();
    expect_val(32'd1); check("bp_masked_state", 32'(state));
    fin_n = 1'b0;
    model_cnt++;
    tick();
    fin_n = 1'b1;
    tick();
    expect_val(32'd4); check("bp_rehit_state", 32'(state));
    expect_val(32'(model_cnt)); check("bp_count", 32'(icount));
    sw_bp = 1'b0;
    repeat (4) tick();
    expect_val(32'd1); check("bp_disable_state", 32'(state));
    hit_n = 1'b1;

    // Instruction counter wrap
    fin_n = 1'b0;
    repeat (32'hFFFF - model_cnt) tick();
    fin_n = 1'b1;
    expect_val(32'h0000FFFF); check("wrap_max", 32'(icount));
    fin_n = 1'b0;
    tick();
    fin_n = 1'b1;
    model_cnt = 0;
    expect_val(32'h00000000); check("wrap_zero", 32'(icount));

    // Leave run mode in instruction mode: drain until the instruction retires
    sw_instr = 1'b1;
    repeat (3) tick();
    sw_step = 1'b1;
    repeat (4) tick();
    expect_val(32'd5); check("drain_state", 32'(state));
    expect_val(32'd0); check("drain_halt", 32'(halt));
    fin_n = 1'b0;
    model_cnt++;
    tick();
    fin_n = 1'b1;
    expect_val(32'd0); check("drain_done_state", 32'(state));
    expect_val(32'(model_cnt)); check("drain_count", 32'(icount));

    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain: observed %0d leftover expectations, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
